// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state encoding and default source count for ext_irq_controller.
package irq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
    localparam int NSRC_DEFAULT = 8;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: parametric-width two-flop synchronizer, asynchronous active-low reset.
module irq_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ext_irq_controller.sv
// ext_irq_controller: edge-latching, maskable, fixed-priority external interrupt controller.
// Define IRQ_SYNC_EN to pass irq_src through a two-flop synchronizer before edge detection.
module ext_irq_controller
    import irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEFAULT,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            eoi,
    input  logic            ExtIAck,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] pending,
    output logic            in_service
);
    state_t          state, next_state;
    logic [NSRC-1:0] src_s, src_prev, mask, eligible, clr;
    logic            load_id;

`ifdef IRQ_SYNC_EN
    irq_sync #(.W(NSRC)) u_sync (
        .clk  (CLOCK_50),
        .rst_n(reset),
        .d    (irq_src),
        .q    (src_s)
    );
`else
    assign src_s = irq_src;
`endif

    function automatic logic [IDW-1:0] lowest(input logic [NSRC-1:0] v);
        lowest = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (v[i]) lowest = IDW'(i);
    endfunction

    assign eligible = pending & mask;
    assign clr      = (state == REQ && ExtIAck) ? (NSRC'(1) << irq_id) : '0;

    always_comb begin
        next_state = state;
        load_id    = 1'b0;
        case (state)
            IDLE: if (|eligible) begin
                next_state = REQ;
                load_id    = 1'b1;
            end
            REQ:     next_state = ExtIAck ? SERV : REQ;
            SERV:    next_state = eoi ? IDLE : SERV;
            default: next_state = IDLE;
        endcase
    end

    // A new edge landing on the acknowledge cycle survives the clear.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            src_prev   <= '0;
            pending    <= '0;
            mask       <= '0;
            irq_id     <= '0;
            ExtIRQ     <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= next_state;
            src_prev   <= src_s;
            pending    <= (pending & ~clr) | (src_s & ~src_prev);
            mask       <= mask_we ? mask_wdata : mask;
            irq_id     <= load_id ? lowest(eligible) : irq_id;
            ExtIRQ     <= next_state == REQ;
            in_service <= next_state == SERV;
        end
    end
endmodule
